// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BHT (2-bit counters) plus BTB for the Fetch stage
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset; clears all entries
//   enable            fetch not stalled; gates predicted_taken only
//   PC_curr           fetch PC used for the combinational lookup (bit 0 ignored)
//   IF_ID_PC_curr     PC of the branch resolved in Decode; selects the entry to update
//   wen_BHT           update the BHT entry for IF_ID_PC_curr
//   actual_taken      resolved branch direction
//   wen_BTB           write the BTB entry for IF_ID_PC_curr
//   actual_target     resolved target stored in the BTB
//   predicted_taken   predicted direction for PC_curr
//   predicted_target  predicted next-fetch address
//   hit               BHT holds a valid entry with a matching tag for PC_curr

module branch_predictor #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 16 - INDEX_BITS - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] PC_curr,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic        wen_BHT,
  input  logic        actual_taken,
  input  logic        wen_BTB,
  input  logic [15:0] actual_target,
  output logic        predicted_taken,
  output logic [15:0] predicted_target,
  output logic        hit
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // Counter encodings
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;

  // BHT storage
  logic                bht_valid [ENTRIES];
  logic [TAG_BITS-1:0] bht_tag   [ENTRIES];
  logic [1:0]          bht_ctr   [ENTRIES];

  // BTB storage; valid and tag are kept apart from the BHT so the two
  // tables can be written independently
  logic                btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [15:0]         btb_target [ENTRIES];

  // Read-side decode of the fetch PC
  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0]   rd_tag;

  // Write-side decode of the Decode-stage PC
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   wr_tag;

  // Lookup results
  logic        bht_match;
  logic        btb_match;
  logic        ctr_says_taken;
  logic [15:0] fall_through;

  // Write-side lookup and counter update
  logic        wr_bht_match;
  logic [1:0]  wr_ctr_next;

  // Byte-offset bits do not participate in indexing
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC_curr[0], IF_ID_PC_curr[0]};

  assign rd_idx = PC_curr[INDEX_BITS:1];
  assign rd_tag = PC_curr[15:INDEX_BITS+1];
  assign wr_idx = IF_ID_PC_curr[INDEX_BITS:1];
  assign wr_tag = IF_ID_PC_curr[15:INDEX_BITS+1];

  // Saturating 2-bit counter step
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'd1;
    end
    return res;
  endfunction

  // --------------------------------------------------------------------
  // Fetch-side read: purely combinational, sees pre-write contents when
  // the same index is being written this cycle (no bypass)
  // --------------------------------------------------------------------
  always_comb begin
    bht_match      = bht_valid[rd_idx] && (bht_tag[rd_idx] == rd_tag);
    btb_match      = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    ctr_says_taken = bht_ctr[rd_idx][1];
    // 16-bit add wraps naturally (0xFFFE -> 0x0000)
    fall_through   = PC_curr + 16'd2;
  end

  assign hit             = bht_match;
  // A taken prediction needs a target, so the BTB must also hit
  assign predicted_taken = enable && bht_match && ctr_says_taken && btb_match;
  assign predicted_target = predicted_taken ? btb_target[rd_idx] : fall_through;

  // --------------------------------------------------------------------
  // Decode-side update
  // --------------------------------------------------------------------
  always_comb begin
    wr_bht_match = bht_valid[wr_idx] && (bht_tag[wr_idx] == wr_tag);
    if (wr_bht_match) begin
      wr_ctr_next = ctr_step(bht_ctr[wr_idx], actual_taken);
    end else begin
      // Fresh allocation starts at the weak state matching the outcome
      wr_ctr_next = actual_taken ? CTR_WT : CTR_WNT;
    end
  end

  // BHT state; reset takes priority over any write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_valid[i] <= 1'b0;
        bht_tag[i]   <= '0;
        bht_ctr[i]   <= CTR_WNT;
      end
    end else if (wen_BHT) begin
      bht_valid[wr_idx] <= 1'b1;
      bht_tag[wr_idx]   <= wr_tag;
      bht_ctr[wr_idx]   <= wr_ctr_next;
    end
  end

  // BTB state; independent of the BHT write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (wen_BTB) begin
      btb_valid[wr_idx]  <= 1'b1;
      btb_tag[wr_idx]    <= wr_tag;
      btb_target[wr_idx] <= actual_target;
    end
  end

endmodule
